// File: rtl/fetch_stage.sv
// fetch_stage: PC + imem fetch FSM + IF/ID register with one-entry skid.
// Ports: clk/rst_n, imem req/addr/rvalid/rdata, redirect, id valid/ready/instr/pc, misalign_err, fetch_count.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  state_t      state;
  logic [31:0] pc;
  if_id_t      out_q;
  if_id_t      skid_q;
  logic        vld_q;
  logic        mis_q;
  logic [31:0] cnt_q;

  logic        hs;
  logic [31:0] pc_inc;
  logic [31:0] redir_pc;

  assign hs       = vld_q & id_ready;
  assign pc_inc   = pc + 32'd4;
  assign redir_pc = {redirect_pc[31:2], 2'b00};

  assign imem_req     = (state == S_REQ);
  assign imem_addr    = pc;
  assign id_valid     = vld_q;
  assign id_instr     = out_q.instr;
  assign id_pc        = out_q.pc;
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= {RESET_PC[31:2], 2'b00};
      out_q  <= '{instr: NOP_INSTR, pc: RESET_PC};
      skid_q <= '0;
      vld_q  <= 1'b0;
      mis_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mis_q <= 1'b0;
      if (hs) begin
        cnt_q <= cnt_q + 32'd1;
        vld_q <= 1'b0;
      end
      if (redirect_valid) begin
        pc     <= redir_pc;
        vld_q  <= 1'b0;
        skid_q <= '0;
        mis_q  <= |redirect_pc[1:0];
        // An issued request must have its response swallowed first.
        unique case (state)
          S_REQ:   state <= S_DRAIN;
          S_WAIT:  state <= imem_rvalid ? S_REQ : S_DRAIN;
          S_DRAIN: state <= imem_rvalid ? S_REQ : S_DRAIN;
          default: state <= S_REQ;
        endcase
      end else begin
        unique case (state)
          S_IDLE: state <= S_REQ;
          S_REQ:  state <= S_WAIT;
          S_WAIT: begin
            if (imem_rvalid) begin
              pc <= pc_inc;
              if (!vld_q || id_ready) begin
                out_q <= '{instr: imem_rdata, pc: pc};
                vld_q <= 1'b1;
                state <= S_REQ;
              end else begin
                skid_q <= '{instr: imem_rdata, pc: pc};
                state  <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (id_ready) begin
              out_q <= skid_q;
              vld_q <= 1'b1;
              state <= S_REQ;
            end
          end
          S_DRAIN: begin
            if (imem_rvalid) state <= S_REQ;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
